// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM receive path. Generates the bit clock for an external
// PDM source, synchronizes and samples its 1-bit stream, and decimates it
// with a 3rd-order CIC (differential delay 1) to signed 16-bit PCM.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (priority over en)
//   en       in   block enable; low clears all state like rst
//   pdm_clk  out  bit clock to the PDM source (registered)
//   pdm_data in   asynchronous PDM bitstream
//   smp      out  signed PCM sample, held between strobes
//   smp_vld  out  one-cycle strobe marking a new smp
module pdm_decimator #(
    parameter int unsigned CLK_DIV  = 16,
    parameter int unsigned DEC_LOG2 = 6,
    parameter int unsigned SETTLE   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               pdm_clk,
    input  logic               pdm_data,
    output logic signed [15:0] smp,
    output logic               smp_vld
);

    localparam int unsigned W     = 3 * DEC_LOG2 + 2;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned SET_W = $clog2(SETTLE + 2);
    localparam int unsigned SHIFT = 3 * DEC_LOG2 - 15;

    localparam logic signed [W-1:0] SAT_MAX = W'(32767);
    localparam logic signed [W-1:0] SAT_MIN = W'(-32768);

    logic [DIV_W-1:0]    div_cnt;
    logic [DEC_LOG2-1:0] smp_cnt;
    logic [SET_W-1:0]    set_cnt;
    logic [1:0]          sync_q;

    logic signed [W-1:0] i1, i2, i3;
    logic signed [W-1:0] lat_q;
    logic                lat_vld_q;
    logic signed [W-1:0] c1_dly, c2_dly, c3_dly;

    logic                clear_c;
    logic                bit_stb_c;
    logic                dec_stb_c;
    logic [DIV_W-1:0]    div_nxt_c;
    logic signed [W-1:0] x_c;
    logic signed [W-1:0] i1_nxt_c, i2_nxt_c, i3_nxt_c;
    logic signed [W-1:0] c1_nxt_c, c2_nxt_c, c3_nxt_c;
    logic signed [W-1:0] y_c;
    logic signed [15:0]  sat_c;

    // Next-state datapath: divider, integrators, comb chain and output scaling.
    always_comb begin
        clear_c   = rst || !en;
        bit_stb_c = (div_cnt == DIV_W'(CLK_DIV - 1));
        div_nxt_c = bit_stb_c ? '0 : div_cnt + DIV_W'(1);
        dec_stb_c = bit_stb_c && (smp_cnt == '1);

        // Bit 1 -> +1, bit 0 -> -1 (all ones in two's complement).
        x_c = sync_q[1] ? W'(1) : {W{1'b1}};

        // Wrapping sums; the comb differences recover the true value.
        i1_nxt_c = i1 + x_c;
        i2_nxt_c = i2 + i1_nxt_c;
        i3_nxt_c = i3 + i2_nxt_c;

        c1_nxt_c = lat_q - c1_dly;
        c2_nxt_c = c1_nxt_c - c2_dly;
        c3_nxt_c = c2_nxt_c - c3_dly;

        y_c = c3_nxt_c >>> SHIFT;
        if (y_c > SAT_MAX) begin
            sat_c = 16'sh7fff;
        end else if (y_c < SAT_MIN) begin
            sat_c = 16'sh8000;
        end else begin
            sat_c = y_c[15:0];
        end
    end

    // Two-flop synchronizer for the asynchronous bitstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pdm_data};
        end
    end

    // Main state: everything clears on reset or while disabled.
    always_ff @(posedge clk) begin
        if (clear_c) begin
            div_cnt   <= '0;
            smp_cnt   <= '0;
            set_cnt   <= '0;
            pdm_clk   <= 1'b0;
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            lat_q     <= '0;
            lat_vld_q <= 1'b0;
            c1_dly    <= '0;
            c2_dly    <= '0;
            c3_dly    <= '0;
            smp       <= '0;
            smp_vld   <= 1'b0;
        end else begin
            div_cnt   <= div_nxt_c;
            // Registered from the next count so the high phase lines up with div_cnt.
            pdm_clk   <= (div_nxt_c >= DIV_W'(CLK_DIV / 2));
            lat_vld_q <= dec_stb_c;
            smp_vld   <= 1'b0;

            if (bit_stb_c) begin
                i1      <= i1_nxt_c;
                i2      <= i2_nxt_c;
                i3      <= i3_nxt_c;
                smp_cnt <= smp_cnt + DEC_LOG2'(1);
            end

            if (dec_stb_c) begin
                lat_q <= i3_nxt_c;
            end

            if (lat_vld_q) begin
                c1_dly <= lat_q;
                c2_dly <= c1_nxt_c;
                c3_dly <= c2_nxt_c;
                if (set_cnt == SET_W'(SETTLE)) begin
                    smp     <= sat_c;
                    smp_vld <= 1'b1;
                end else begin
                    set_cnt <= set_cnt + SET_W'(1);
                end
            end
        end
    end

endmodule
